// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if
//   Bundles the three handshake groups around the ALU command sequencer:
//   host command push (cmd_*), ALU drive/observe (alu_*), and response
//   return plus status (rsp_*, err_sticky, op_count).
//   slave  : the sequencer side.
//   master : the host / ALU / response-consumer side.
interface alu_cmd_sequencer_if #(
   parameter int DATALEN  = 8,
   parameter int MODELEN  = 4,
   parameter int ERRORLEN = 2
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic [DATALEN-1:0]  cmd_a;
   logic [DATALEN-1:0]  cmd_b;
   logic [MODELEN-1:0]  cmd_mode;
   logic                cmd_clear;

   logic [DATALEN-1:0]  alu_a;
   logic [DATALEN-1:0]  alu_b;
   logic [MODELEN-1:0]  alu_mode;
   logic                alu_clear;
   logic [DATALEN-1:0]  alu_out;
   logic [ERRORLEN-1:0] alu_err;

   logic                rsp_valid;
   logic                rsp_ready;
   logic [DATALEN-1:0]  rsp_data;
   logic [ERRORLEN-1:0] rsp_err;
   logic [ERRORLEN-1:0] err_sticky;
   logic [7:0]          op_count;

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_mode, cmd_clear,
      output cmd_ready,
      output alu_a, alu_b, alu_mode, alu_clear,
      input  alu_out, alu_err,
      output rsp_valid, rsp_data, rsp_err, err_sticky, op_count,
      input  rsp_ready
   );

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_mode, cmd_clear,
      input  cmd_ready,
      input  alu_a, alu_b, alu_mode, alu_clear,
      output alu_out, alu_err,
      input  rsp_valid, rsp_data, rsp_err, err_sticky, op_count,
      output rsp_ready
   );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Queues host ALU commands in a DEPTH-entry FIFO and issues them one at a
//   time to an accumulator ALU. Each op takes IDLE/RESP -> ISSUE -> CAPTURE
//   -> RESP: the ALU sees the command for one cycle (ISSUE), its error is
//   latched at the end of ISSUE, and the accumulator is sampled at the end
//   of CAPTURE into the response register.
// Ports
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (aborts the op, flushes the FIFO)
//   bus   : alu_cmd_sequencer_if.slave (cmd_*, alu_*, rsp_*, err_sticky,
//           op_count)
module alu_cmd_sequencer #(
   parameter int DATALEN  = 8,
   parameter int MODELEN  = 4,
   parameter int ERRORLEN = 2,
   parameter int DEPTH    = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   alu_cmd_sequencer_if.slave   bus
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]        FULL_CNT  = (AW+1)'(DEPTH);
   localparam logic [MODELEN-1:0] NO_CHANGE = '0;

   typedef struct packed {
      logic [DATALEN-1:0] a;
      logic [DATALEN-1:0] b;
      logic [MODELEN-1:0] mode;
      logic               clear;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

   state_t              state;
   cmd_t                mem [DEPTH];
   cmd_t                head;
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [AW:0]         count;
   logic                full, empty, push, pop;
   logic [ERRORLEN-1:0] err_hold;

   assign full          = (count == FULL_CNT);
   assign empty         = (count == '0);
   assign bus.cmd_ready = !full;
   // Refused when full even if a pop lands in the same cycle.
   assign push          = bus.cmd_valid && !full;
   // Pop only from IDLE or on the response handshake; never bypasses the
   // FIFO since the FSM reads registered occupancy.
   assign pop           = !empty && ((state == IDLE) ||
                                     (state == RESP && bus.rsp_ready));
   assign head          = mem[rd_ptr];

   // ---------------- FIFO ----------------
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{a: bus.cmd_a, b: bus.cmd_b,
                                 mode: bus.cmd_mode, clear: bus.cmd_clear};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ---------------- Sequencer FSM ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         bus.alu_a      <= '0;
         bus.alu_b      <= '0;
         bus.alu_mode   <= NO_CHANGE;
         // Held high in reset so the ALU accumulator clears every edge.
         bus.alu_clear  <= 1'b1;
         err_hold       <= '0;
         bus.rsp_valid  <= 1'b0;
         bus.rsp_data   <= '0;
         bus.rsp_err    <= '0;
         bus.err_sticky <= '0;
         bus.op_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               bus.alu_mode  <= NO_CHANGE;
               bus.alu_clear <= 1'b0;
               if (pop) begin
                  bus.alu_a     <= head.a;
                  bus.alu_b     <= head.b;
                  bus.alu_mode  <= head.mode;
                  bus.alu_clear <= head.clear;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               // alu_err is combinational from the presented mode, so it is
               // only meaningful during this cycle.
               err_hold      <= bus.alu_err;
               bus.alu_mode  <= NO_CHANGE;
               bus.alu_clear <= 1'b0;
               state         <= CAPTURE;
            end
            CAPTURE: begin
               bus.rsp_data  <= bus.alu_out;
               bus.rsp_err   <= err_hold;
               bus.rsp_valid <= 1'b1;
               state         <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid  <= 1'b0;
                  bus.op_count   <= bus.op_count + 8'd1;
                  bus.err_sticky <= bus.err_sticky | bus.rsp_err;
                  if (pop) begin
                     bus.alu_a     <= head.a;
                     bus.alu_b     <= head.b;
                     bus.alu_mode  <= head.mode;
                     bus.alu_clear <= head.clear;
                     state         <= ISSUE;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Upstream command stage for the accumulator ALU. A host pushes operation commands {inA, inB, mode, clear} into a DEPTH-entry FIFO over a valid/ready handshake. The sequencer issues one command at a time to the ALU, samples the ALU error and accumulator result at the correct cycles, and returns them on a valid/ready response port. It also keeps a sticky error summary and a completed-operation counter.

## Interface
- DATALEN, 8, data width; must match the ALU datalen
- MODELEN, 4, mode code width
- ERRORLEN, 2, error code width
- DEPTH, 4, command FIFO entries; power of two, ≥2
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- cmd_valid  input  1  host command present
- cmd_ready  output  1  FIFO can accept a command
- cmd_a  input  DATALEN  operand A
- cmd_b  input  DATALEN  operand B
- cmd_mode  input  MODELEN  ALU function code
- cmd_clear  input  1  clear accumulator with this command
- alu_a  output  DATALEN  to ALU inA
- alu_b  output  DATALEN  to ALU inB
- alu_mode  output  MODELEN  to ALU mode
- alu_clear  output  1  to ALU clear
- alu_out  input  DATALEN  ALU accumulator output
- alu_err  input  ERRORLEN  ALU error (combinational from presented mode)
- rsp_valid  output  1  response held
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  DATALEN  accumulator value after the op
- rsp_err  output  ERRORLEN  error code of the op
- err_sticky  output  ERRORLEN  OR of all returned rsp_err
- op_count  output  8  completed responses, modulo 256

## Operation
- Mode codes:
  - NoChange 0000, Load 0100, NOT 0001, AND 0101, OR 0110, XOR 0111.
  - Add 1000, Subtract 1001, ShiftLeft 0010, ShiftRight 0011.
  - Errors: 00 none, 01 overflow, 10 underflow.
- FIFO:
  - Push on cmd_valid && cmd_ready. cmd_ready = !full; it is a pure function of occupancy.
  - When full, a push is refused even if a pop happens in the same cycle.
  - There is no bypass. A command pushed at edge p pops at edge p+1 at the earliest.
  - Pointers wrap modulo DEPTH. Occupancy count is 0..DEPTH.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
  - IDLE: if the FIFO is non-empty, pop, register the entry into alu_a/alu_b/alu_mode/alu_clear, and go to ISSUE.
  - ISSUE: the ALU sees the command for this whole cycle. At the edge:
    - latch alu_err into err_hold;
    - set alu_mode ← NoChange and alu_clear ← 0; alu_a/alu_b hold;
    - go to CAPTURE.
  - CAPTURE: alu_out now reflects the op. At the edge:
    - rsp_data ← alu_out, rsp_err ← err_hold, rsp_valid ← 1;
    - go to RESP.
  - RESP: hold rsp_* stable while rsp_ready=0. On rsp_ready=1 at the edge:
    - rsp_valid ← 0, op_count ← op_count+1, err_sticky ← err_sticky | rsp_err;
    - if the FIFO is non-empty, pop and go directly to ISSUE; otherwise go to IDLE.
- Outside ISSUE, alu_mode is always NoChange, so the ALU accumulator holds its value.
- A command with cmd_clear=1 zeroes the accumulator; its rsp_data is 0x00 regardless of mode.
- op_count wraps 255→0. err_sticky is cleared only by reset.

## Timing
- All outputs are registered, except cmd_ready, which is derived from the registered count.
- Reset (async assert, sync release) values:
  - FIFO empty; cmd_ready=1; state IDLE;
  - alu_a=0, alu_b=0, alu_mode=NoChange, alu_clear=1;
  - rsp_valid=0, rsp_data=0, rsp_err=0, err_sticky=0, op_count=0.
- alu_clear=1 throughout reset, so the ALU accumulator clears on every clk edge while reset is low. alu_clear drops to 0 at the first edge after release.
- Latency, pop edge e0 → rsp_valid high after edge e0+2. From push, rsp_valid rises no earlier than 3 edges later.
- Throughput: one op per 3 cycles with rsp_ready held high.
- Reset mid-operation (any state) aborts the op and flushes the FIFO. No response is produced for in-flight or queued commands.
- Simultaneous push and pop when non-full: both occur and the count is unchanged.

## Test plan
- Reset release, then push Load A=0x51 → alu_mode=0100 for exactly one cycle; rsp_valid 3 edges after push with rsp_data=0x51, rsp_err=00; op_count=1.
- Load 0x51, then ShiftLeft, then ShiftRight → rsp_data 0x51, 0xA2, 0x51 in order; each op is 3 cycles apart with rsp_ready=1.
- Load 0x55 → 0x55; OR A=0x55 B=0x58 → 0x5D; XOR A=0x55 B=0x58 → 0x0D; AND A=0x55 B=0x58 → 0x50.
- Hold rsp_ready=0 for 10 cycles while pushing 6 commands:
  - rsp_data stays stable and alu_mode stays NoChange;
  - cmd_ready=0 once DEPTH=4 are queued plus one is in RESP;
  - on release, responses drain in push order.
- Command with cmd_clear=1, mode Load, A=0xFF → rsp_data=0x00.
- Drive alu_err=01 during ISSUE → rsp_err=01; err_sticky=01 after the handshake; err_sticky persists through later error-free ops.
- Assert reset during ISSUE with 3 commands queued:
  - immediately: rsp_valid=0, cmd_ready=1, alu_clear=1, op_count=0;
  - after release, Load 0x3C → rsp_data=0x3C.
